// File: rtl/mcs6530_timer.sv
// Programmable interval timer: 8-bit down-counter with a /1, /8, /64 or /1024 prescaler, IRQ flag and active-low IRQ.
// Latency: count and irq_flag update one phi2 edge after the causing strobe; timer_irq is combinational from flops.
// Backpressure: none; every wr_en / rd_timer strobe is accepted on the edge where it is high.
module mcs6530_timer #(
  parameter logic [7:0] RESET_COUNT = 8'hFF,
  parameter logic [1:0] RESET_DIV   = 2'b11
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [1:0] div_sel,
  input  logic       irq_en_wr,
  input  logic       rd_timer,
  output logic [7:0] count,
  output logic       irq_flag,
  output logic       timer_irq
);

  logic [7:0] count_q,    count_d;
  logic [9:0] pre_q,      pre_d;
  logic [1:0] div_q,      div_d;
  logic       irq_en_q,   irq_en_d;
  logic       irq_flag_q, irq_flag_d;
  logic [9:0] pre_term;

  // Terminal prescaler value (N-1) for the currently selected divider.
  always_comb begin
    pre_term = 10'd1023;
    case (div_q)
      2'b00:   pre_term = 10'd0;
      2'b01:   pre_term = 10'd7;
      2'b10:   pre_term = 10'd63;
      default: pre_term = 10'd1023;
    endcase
  end

  // Next-state: a write wins over everything; timed-out mode counts every edge
  // until a timer read re-arms the prescaler; otherwise count on prescaler terminal.
  always_comb begin
    count_d    = count_q;
    pre_d      = pre_q;
    div_d      = div_q;
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    if (wr_en) begin
      count_d    = wr_data;
      pre_d      = 10'd0;
      div_d      = div_sel;
      irq_en_d   = irq_en_wr;
      irq_flag_d = 1'b0;
    end else if (irq_flag_q) begin
      count_d = count_q - 8'd1;
      pre_d   = 10'd0;
      if (rd_timer) begin
        irq_flag_d = 1'b0;
      end
    end else if (pre_q == pre_term) begin
      pre_d   = 10'd0;
      count_d = count_q - 8'd1;
      // Decrementing through zero is the timeout event.
      if (count_q == 8'h00) begin
        irq_flag_d = 1'b1;
      end
    end else begin
      pre_d = pre_q + 10'd1;
    end
  end

  // State registers with synchronous reset overriding all strobes.
  always_ff @(posedge phi2) begin
    if (rst) begin
      count_q    <= RESET_COUNT;
      pre_q      <= 10'd0;
      div_q      <= RESET_DIV;
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      pre_q      <= pre_d;
      div_q      <= div_d;
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  assign count     = count_q;
  assign irq_flag  = irq_flag_q;
  assign timer_irq = ~(irq_flag_q & irq_en_q);

endmodule

// File: doc/mcs6530_timer.md
Name: mcs6530_timer

Overview:
- Programmable interval timer inside the mcs6530 core.
- Sits downstream of the pin/IO layer: it receives latched address, data and R/W decodes from the core register file.
- It produces the active-low timer_irq that drives PB7 in the IO layer, plus the count and flag values returned on data reads.
- Behaviour: 8-bit down-counter with a selectable 1/8/64/1024 prescaler. After the count passes zero, it runs at one decrement per clock.

Parameters:
- RESET_COUNT, 8'hFF, counter value loaded on reset.
- RESET_DIV, 2'b11, divider select loaded on reset (11 = divide-by-1024).

Ports:
- phi2  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  single-cycle timer write strobe, already decoded by the core.
- wr_data  input  8  initial count written on wr_en.
- div_sel  input  2  divider select sampled on wr_en: 00 = /1, 01 = /8, 10 = /64, 11 = /1024.
- irq_en_wr  input  1  IRQ enable bit sampled on wr_en (address bit A3 in the core).
- rd_timer  input  1  single-cycle strobe: CPU read of the timer register.
- count  output  8  current counter value, registered.
- irq_flag  output  1  timeout flag, registered; read by the core as status bit 7.
- timer_irq  output  1  active-low interrupt, equal to ~(irq_flag & irq_en).

Behaviour:
- Internal state:
  - count[7:0]
  - prescaler[9:0]
  - div[1:0]
  - irq_en
  - irq_flag
- Divider lengths: N = 1, 8, 64, 1024 for div = 00, 01, 10, 11.
- Reset (rst high at an edge): count = RESET_COUNT, prescaler = 0, div = RESET_DIV, irq_en = 0, irq_flag = 0, timer_irq = 1. Reset overrides every other input.
- Write (wr_en high at edge t):
  - count = wr_data, prescaler = 0, div = div_sel, irq_en = irq_en_wr, irq_flag = 0.
  - No decrement happens in that cycle.
  - Write has priority over rd_timer and over underflow in the same cycle.
- Prescaled mode (irq_flag = 0):
  - Every edge, prescaler increments.
  - When prescaler == N-1: prescaler becomes 0 and count decrements by 1.
  - With N = 1, count decrements every edge.
- Underflow:
  - A decrement taken while count == 8'h00 wraps count to 8'hFF and sets irq_flag = 1.
  - A write of D with divider N therefore sets irq_flag exactly N*(D+1) edges after the write edge.
  - D = 0 is legal: the flag sets N edges after the write.
- Timed-out mode (irq_flag = 1):
  - count decrements by 1 on every edge, wrapping FF to 00 to FF freely.
  - prescaler is held at 0.
  - irq_flag stays set.
- rd_timer while irq_flag = 1 (and no wr_en):
  - irq_flag clears and prescaled mode resumes with prescaler = 0.
  - count still decrements by 1 on that edge (timed-out rate).
  - The core samples count before the edge.
- rd_timer while irq_flag = 0: no side effect; prescaler and count advance normally.
- rd_timer on the same edge as an underflow: underflow wins, so irq_flag = 1 afterwards.
- Status read: reading irq_flag through the core never clears it. Only rd_timer, wr_en or rst clear it.
- timer_irq is combinational from the registered irq_flag and irq_en; it is glitch-free because it depends on flops only.
- Width rules: count arithmetic is modulo 256. prescaler compare uses the full 10 bits, so the maximum terminal value is 1023.
- Latency: count and irq_flag are visible one edge after the causing event. timer_irq follows irq_flag with zero extra latency.

Test Plan:
- Reset: assert rst 1 cycle -> count = FF, irq_flag = 0, timer_irq = 1. Next 1023 edges count holds FF; edge 1024 gives count = FE.
- Write D = 03, div_sel = 01, irq_en_wr = 1 -> count = 03. Count reaches 02 at edge +8, 01 at +16, 00 at +24. At +32 count = FF, irq_flag = 1, timer_irq = 0. At +33 count = FE.
- Write D = 00, div_sel = 00, irq_en_wr = 0 -> at +1 count = FF and irq_flag = 1, but timer_irq stays 1. Count then decrements every edge.
- After a timeout (flag set, count = F0), pulse rd_timer -> next edge irq_flag = 0, timer_irq = 1, count = EF. Count then holds for 7 edges (div /8) before reaching EE.
- Simultaneity:
  - wr_en together with rd_timer and underflow -> write values win, irq_flag = 0.
  - rd_timer on the underflow edge with no write -> irq_flag = 1.
- Reset mid-count: div /64, count = 10, prescaler = 30, assert rst -> count = FF, div = /1024, prescaler = 0, irq_flag = 0 on the next edge.
